// File: rtl/clk_gen_pkg.sv
// Shared definitions for the cascaded clock phase generator.
package clk_gen_pkg;

   localparam int DIV_W_DEF = 8;
   localparam int MAX_CH    = 8;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } halt_state_e;

   // Channel period in master cycles for a packed half-period vector.
   // Fields are DIV_W_DEF wide; channel k's period is the product of
   // 2*half[j] over every channel j up to and including k.
   function automatic longint unsigned period_of(
      input logic [MAX_CH*DIV_W_DEF-1:0] half,
      input int                          k
   );
      longint unsigned p;
      p = 64'd1;
      for (int j = 0; j < MAX_CH; j++) begin
         if (j <= k) begin
            p = p * 64'd2 * 64'(half[j*DIV_W_DEF +: DIV_W_DEF]);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One divider channel: counts advance pulses and toggles its clock level
// every 'half' advances. next_rise is combinational so a child stage can
// advance on the same master edge as this stage's rising transition.
module clk_div_stage
   import clk_gen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             adv,
   input  logic [DIV_W-1:0] half,
   output logic             clk,
   output logic             rise,
   output logic             next_rise,
   output logic             at_zero
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             rise_q;
   logic             wrap;

   assign wrap      = (cnt_q == (half - ONE));
   assign next_rise = adv & wrap & ~clk_q;
   assign at_zero   = (cnt_q == '0) & ~clk_q;
   assign clk       = clk_q;
   assign rise      = rise_q;

   // Next counter value and level for this advance.
   always_comb begin
      cnt_d = cnt_q;
      clk_d = clk_q;
      if (adv) begin
         if (wrap) begin
            cnt_d = '0;
            clk_d = ~clk_q;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   // Counter, level and rise strobe registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         rise_q <= next_rise;
      end
   end

endmodule

// File: rtl/clock_phase_gen.sv
// Cascaded divided-clock generator with halt/ack freeze at the common
// phase origin and a reset stretched over slowest-channel rising edges.
//
// state  | meaning
// RUN    | channels advance every master cycle
// HALTED | all channels frozen at the phase origin, halt_ack high
module clock_phase_gen
   import clk_gen_pkg::*;
#(
   parameter int                      NUM_CH       = 2,
   parameter int                      DIV_W        = DIV_W_DEF,
   parameter logic [NUM_CH*DIV_W-1:0] HALF         = {8'd1, 8'd1},
   parameter int                      RESET_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              halt_req,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise,
   output logic              halt_ack,
   output logic              reset_out
);

   localparam logic [7:0] RC8 = 8'(RESET_CYCLES);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("clock_phase_gen: NUM_CH must be 1..8");
   end
   if (RESET_CYCLES < 0 || RESET_CYCLES > 255) begin : g_bad_rst_cycles
      $error("clock_phase_gen: RESET_CYCLES must be 0..255");
   end

   logic [NUM_CH-1:0] adv_w;
   logic [NUM_CH-1:0] next_rise_w;
   logic [NUM_CH-1:0] at_zero_w;
   logic [NUM_CH-1:0] clk_w;
   logic [NUM_CH-1:0] rise_w;

   halt_state_e state_q, state_d;
   logic        run;
   logic        at_origin;
   logic        halt_ack_q, halt_ack_d;
   logic [7:0]  rcnt_q, rcnt_d;
   logic        reset_out_q, reset_out_d;

   assign at_origin = &at_zero_w;
   assign adv_w[0]  = run;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      if (HALF[k*DIV_W +: DIV_W] == '0) begin : g_bad_half
         $error("clock_phase_gen: HALF field must be >= 1");
      end
      if (k > 0) begin : g_chain
         // Child advances on the parent's rising transition, same edge.
         assign adv_w[k] = next_rise_w[k-1];
      end
      clk_div_stage #(
         .DIV_W (DIV_W)
      ) u_stage (
         .clock     (clock),
         .reset     (reset),
         .adv       (adv_w[k]),
         .half      (HALF[k*DIV_W +: DIV_W]),
         .clk       (clk_w[k]),
         .rise      (rise_w[k]),
         .next_rise (next_rise_w[k]),
         .at_zero   (at_zero_w[k])
      );
   end

   assign clk_out   = clk_w;
   assign rise      = rise_w;
   assign halt_ack  = halt_ack_q;
   assign reset_out = reset_out_q;

   // Halt FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Halt FSM next state: halt only when sitting at the phase origin.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (halt_req && at_origin) state_d = HALTED;
         HALTED:  if (!halt_req)             state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Halt FSM outputs: the freezing cycle itself must not advance.
   always_comb begin
      run        = (state_q == RUN) & ~(halt_req & at_origin);
      halt_ack_d = (state_d == HALTED);
   end

   // Reset stretcher: counts slowest-channel rises one cycle early via
   // next_rise, so comparing the registered count lands reset_out one
   // cycle after the final rise strobe is visible.
   always_comb begin
      rcnt_d = rcnt_q;
      if (next_rise_w[NUM_CH-1] && (rcnt_q != 8'hFF)) begin
         rcnt_d = rcnt_q + 8'd1;
      end
      reset_out_d = (rcnt_q < RC8);
   end

   // Halt acknowledge and reset stretcher registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         halt_ack_q  <= 1'b0;
         rcnt_q      <= 8'd0;
         reset_out_q <= 1'b1;
      end else begin
         halt_ack_q  <= halt_ack_d;
         rcnt_q      <= rcnt_d;
         reset_out_q <= reset_out_d;
      end
   end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: three configurations driven by shared
// reset/halt stimulus, compared each cycle against a phase-arithmetic model.
module tb_clock_phase_gen;
   import clk_gen_pkg::*;

   logic       clock = 1'b0;
   logic       rst;
   logic       hreq;

   logic [1:0] co0, ri0;
   logic [2:0] co1, ri1;
   logic [1:0] co2, ri2;
   logic       ha0, ha1, ha2;
   logic       ro0, ro1, ro2;

   always #5 clock = ~clock;

   clock_phase_gen u_dut0 (
      .clock(clock), .reset(rst), .halt_req(hreq),
      .clk_out(co0), .rise(ri0), .halt_ack(ha0), .reset_out(ro0)
   );

   clock_phase_gen #(
      .NUM_CH(3), .HALF({8'd3, 8'd2, 8'd1}), .RESET_CYCLES(4)
   ) u_dut1 (
      .clock(clock), .reset(rst), .halt_req(hreq),
      .clk_out(co1), .rise(ri1), .halt_ack(ha1), .reset_out(ro1)
   );

   clock_phase_gen #(
      .NUM_CH(2), .HALF({8'd1, 8'd5}), .RESET_CYCLES(0)
   ) u_dut2 (
      .clock(clock), .reset(rst), .halt_req(hreq),
      .clk_out(co2), .rise(ri2), .halt_ack(ha2), .reset_out(ro2)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int          nch [3];
   int          hlf [3][8];
   int          rcy [3];
   int unsigned per [3][8];
   int unsigned tr  [3][8];

   int unsigned ph     [3];
   bit          halted [3];
   int          nrise  [3];
   logic [7:0]  m_clk  [3];
   logic [7:0]  m_rise [3];
   logic        m_ack  [3];
   logic        m_rout [3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Periods from the package helper; first-rise offsets from the rule
   // that channel k first rises after (half[k]-1) full parent periods
   // following the parent's first rise.
   task automatic setup_model();
      logic [MAX_CH*DIV_W_DEF-1:0] hv;
      nch = '{2, 3, 2};
      rcy = '{4, 4, 0};
      for (int i = 0; i < 3; i++) for (int k = 0; k < 8; k++) hlf[i][k] = 0;
      hlf[0][0] = 1; hlf[0][1] = 1;
      hlf[1][0] = 1; hlf[1][1] = 2; hlf[1][2] = 3;
      hlf[2][0] = 5; hlf[2][1] = 1;
      for (int i = 0; i < 3; i++) begin
         hv = '0;
         for (int k = 0; k < 8; k++) hv[k*8 +: 8] = 8'(hlf[i][k]);
         for (int k = 0; k < nch[i]; k++) begin
            per[i][k] = int'(period_of(hv, k));
            if (k == 0) tr[i][k] = 32'(hlf[i][0]);
            else        tr[i][k] = tr[i][k-1] + 32'(hlf[i][k] - 1) * per[i][k-1];
         end
         ph[i] = 0; halted[i] = 0; nrise[i] = 0;
      end
   endtask

   task automatic model_edge(input int i);
      int unsigned ps, phase;
      bit adv;
      ps  = per[i][nch[i]-1];
      adv = 0;
      if (rst) begin
         ph[i] = 0; halted[i] = 0; nrise[i] = 0; m_rout[i] = 1'b1;
      end else begin
         m_rout[i] = (nrise[i] < rcy[i]);
         if (halted[i]) begin
            if (!hreq) halted[i] = 0;
         end else if (hreq && ph[i] == 0) begin
            halted[i] = 1;
         end else begin
            ph[i] = (ph[i] + 1) % ps;
            adv   = 1;
         end
      end
      m_ack[i]  = halted[i];
      m_clk[i]  = '0;
      m_rise[i] = '0;
      for (int k = 0; k < nch[i]; k++) begin
         phase = ph[i] % per[i][k];
         if (phase >= tr[i][k] && phase < tr[i][k] + per[i][k] / 2) m_clk[i][k] = 1'b1;
         if (adv && phase == tr[i][k]) m_rise[i][k] = 1'b1;
      end
      if (!rst && m_rise[i][nch[i]-1] && nrise[i] < 255) nrise[i]++;
   endtask

   task automatic step();
      logic [31:0] gc, gr, ga, go;
      @(posedge clock);
      cyc++;
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin gc = 32'(co0); gr = 32'(ri0); ga = 32'(ha0); go = 32'(ro0); end
            1:       begin gc = 32'(co1); gr = 32'(ri1); ga = 32'(ha1); go = 32'(ro1); end
            default: begin gc = 32'(co2); gr = 32'(ri2); ga = 32'(ha2); go = 32'(ro2); end
         endcase
         check_eq($sformatf("d%0d.clk_out", i), gc, 32'(m_clk[i]));
         check_eq($sformatf("d%0d.rise", i), gr, 32'(m_rise[i]));
         check_eq($sformatf("d%0d.halt_ack", i), ga, 32'(m_ack[i]));
         check_eq($sformatf("d%0d.reset_out", i), go, 32'(m_rout[i]));
      end
   endtask

   initial begin
      setup_model();
      rst  = 1'b1;
      hreq = 1'b0;

      // Plain run after a 3-cycle reset.
      repeat (3) step();
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (c == 1)  check_eq("d0.first_rise", 32'(ri0), 32'h3);
         if (c == 13) check_eq("d0.rout_before_fall", 32'(ro0), 32'h1);
         if (c == 14) check_eq("d0.rout_fall", 32'(ro0), 32'h0);
      end

      // Halt requested mid-period; freeze at the next origin, then release.
      rst = 1'b1; step(); rst = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         step();
         if (c == 8)  check_eq("d0.ack_pre_halt", 32'(ha0), 32'h0);
         if (c == 9)  check_eq("d0.ack_halted", 32'(ha0), 32'h1);
         if (c == 20) check_eq("d0.frozen_clk", 32'(co0), 32'h0);
         if (c == 5)  hreq = 1'b1;
         if (c == 30) hreq = 1'b0;
      end

      // Two-cycle halt pulse away from every origin.
      rst = 1'b1; step(); rst = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c == 4) check_eq("d0.pulse_no_ack", 32'(ha0), 32'h0);
         if (c == 1) hreq = 1'b1;
         if (c == 3) hreq = 1'b0;
      end

      // Reset while halted with halt_req held: halts again immediately.
      hreq = 1'b1;
      repeat (60) step();
      rst = 1'b1; step(); rst = 1'b0;
      repeat (5) step();
      hreq = 1'b0;
      repeat (60) step();

      // Randomized halt requests and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) hreq = ~hreq;
         step();
      end

      // Long free run so the slowest channels complete several periods.
      rst = 1'b1; hreq = 1'b0; step(); rst = 1'b0;
      repeat (200) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
